// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master side is the pipeline; the slave side is div_unit.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output flush, req_valid, op, in1, in2, resp_ready,
        input  req_ready, resp_valid, out, busy
    );

    modport slave (
        input  flush, req_valid, op, in1, in2, resp_ready,
        output req_ready, resp_valid, out, busy
    );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to answer divide-by-zero and signed overflow straight from accept.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;       // raw dividend, kept for the divide-by-zero remainder
    logic [WIDTH-1:0]   b_q, b_d;       // raw divisor at accept, magnitude from PREP on
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;

    logic               in_signed;
    logic               in_div0;
    logic               in_ovf;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   fix_res;

    function automatic logic [WIDTH-1:0] special_result(
        input logic             is_rem,
        input logic             div0,
        input logic [WIDTH-1:0] dividend
    );
        if (div0) begin
            return is_rem ? dividend : '1;
        end
        return is_rem ? '0 : MIN_NEG;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        fix_res = '0;

        in_signed = ~bus.op[0];
        in_div0   = (bus.in2 == '0);
        in_ovf    = in_signed && (bus.in1 == MIN_NEG) && (bus.in2 == '1);

        // One-bit-wider partial remainder so the trial subtract keeps its borrow.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    op_d    = bus.op;
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                    a_neg_d = in_signed & bus.in1[WIDTH-1];
                    b_neg_d = in_signed & bus.in2[WIDTH-1];
                    div0_d  = in_div0;
                    ovf_d   = in_ovf;
                    state_d = S_PREP;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0 || in_ovf) begin
                        out_d   = special_result(bus.op[1], in_div0, bus.in1);
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_PREP: begin
                quo_d   = a_neg_q ? -a_q : a_q;
                b_d     = b_neg_q ? -b_q : b_q;
                rem_d   = '0;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = S_CALC;
            end
            S_CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q[1]) begin
                    fix_res = a_neg_q ? -rem_q : rem_q;
                end else begin
                    fix_res = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
                end
                if (div0_q || ovf_q) begin
                    fix_res = special_result(op_q[1], div0_q, a_q);
                end
                out_d   = fix_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A kill from the pipeline beats accept and response hand-off alike.
        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_valid = (state_q == S_DONE);
    assign bus.out        = out_q;
endmodule
